// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RST,
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    ALUWB,
    BRANCHEX,
    ADDIEX,
    ANDIEX,
    IMMWB,
    JEX
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b000001;
  localparam logic [5:0] OP_BGE   = 6'b100110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_BLT, OP_BGE, OP_ADDI, OP_ANDI, OP_J: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control-unit <-> datapath signal bundle; master is the controller side.
interface mc_controller_if;
  logic [5:0] op;
  logic       zero;
  logic       neg;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       illegal;

  modport master (
    input  op, zero, neg, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal
  );

  modport slave (
    output op, zero, neg, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal
  );
endinterface

// File: rtl/mc_branch_cond.sv
// Branch-taken evaluation from the rs-rt subtraction flags.
module mc_branch_cond
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       neg,
  output logic       taken
);

  // BLT/BGE rely on the sign of rs-rt, i.e. a signed compare without overflow handling
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = ~zero;
      OP_BLT:  taken = neg;
      OP_BGE:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore decode of the state register plus
// mem_ready qualifiers on fetch, and the branch-qualified PC enable.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  mc_controller_if.master bus
);

  statetype_t state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic       ready;
  logic       taken;
  logic       pcwrite;
  logic       branch;

  assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  mc_branch_cond u_branch_cond (
    .op    (bus.op),
    .zero  (bus.zero),
    .neg   (bus.neg),
    .taken (taken)
  );

  // LW/SW is resolved in DECODE so MEMADR never needs to look at op again
  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    case (state_q)
      S_RST:    state_d = FETCH;
      FETCH:    if (ready) state_d = DECODE;
      DECODE: begin
        is_sw_d = (bus.op == OP_SW);
        case (bus.op)
          OP_LW, OP_SW:                     state_d = MEMADR;
          OP_RTYPE:                         state_d = RTYPEEX;
          OP_BEQ, OP_BNE, OP_BLT, OP_BGE:   state_d = BRANCHEX;
          OP_ADDI:                          state_d = ADDIEX;
          OP_ANDI:                          state_d = ANDIEX;
          OP_J:                             state_d = JEX;
          default:                          state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = is_sw_q ? MEMWR : MEMRD;
      MEMRD:    if (ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWR:    if (ready) state_d = FETCH;
      RTYPEEX:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCHEX: state_d = FETCH;
      ADDIEX:   state_d = IMMWB;
      ANDIEX:   state_d = IMMWB;
      IMMWB:    state_d = FETCH;
      JEX:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  // S_RST decodes to all-zero, so asserting reset_n clears every output at once
  always_comb begin
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = SRCB_REG;
    bus.aluop    = ALUOP_ADD;
    bus.pcsrc    = PCSRC_ALU;
    bus.illegal  = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alusrcb = SRCB_FOUR;
        bus.aluop   = ALUOP_ADD;
        bus.pcsrc   = PCSRC_ALU;
        bus.irwrite = ready;
        pcwrite     = ready;
      end
      DECODE: begin
        bus.alusrcb = SRCB_IMM_SH2;
        bus.aluop   = ALUOP_ADD;
        bus.illegal = ~op_is_legal(bus.op);
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      MEMRD:    bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_REG;
        bus.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      BRANCHEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_REG;
        bus.aluop   = ALUOP_SUB;
        bus.pcsrc   = PCSRC_ALUOUT;
        branch      = 1'b1;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        bus.aluop   = ALUOP_ADD;
      end
      ANDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        bus.aluop   = ALUOP_AND;
      end
      IMMWB:    bus.regwrite = 1'b1;
      JEX: begin
        bus.pcsrc = PCSRC_JUMP;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase
    bus.pcen = pcwrite | (branch & taken);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction step model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mc_controller;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } outs_t;

  localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
  localparam logic [5:0] BEQ_OP = 6'b000100, BNE_OP = 6'b000101, BLT_OP = 6'b000001;
  localparam logic [5:0] BGE_OP = 6'b100110, ADDI_OP = 6'b001000, ANDI_OP = 6'b001100;
  localparam logic [5:0] J_OP = 6'b000010;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  mc_controller_if bus();

  mc_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  outs_t act;
  assign act = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc,
                bus.pcen, bus.illegal};

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  // Reference model: an instruction is a fixed list of steps (fetch, decode,
  // then class-specific), whose length is the documented latency.
  int       m_idx = 0;
  bit       m_rst = 1'b1;
  logic [5:0] m_op = 6'b0;

  function automatic int ilen(input logic [5:0] o);
    case (o)
      LW_OP:                          return 5;
      SW_OP, R_OP, ADDI_OP, ANDI_OP:  return 4;
      BEQ_OP, BNE_OP, BLT_OP, BGE_OP, J_OP: return 3;
      default:                        return 2;
    endcase
  endfunction

  function automatic outs_t mexp(input int idx, input logic [5:0] dop, input logic [5:0] iop,
                                 input logic z, input logic ng, input logic rdy);
    outs_t o;
    logic tk;
    o = '0;
    tk = (iop == BEQ_OP) ? z : (iop == BNE_OP) ? !z : (iop == BLT_OP) ? ng :
         (iop == BGE_OP) ? !ng : 1'b0;
    if (idx == 0) begin
      o.alusrcb = 2'b01; o.irwrite = rdy; o.pcen = rdy;
    end else if (idx == 1) begin
      o.alusrcb = 2'b11; o.illegal = (ilen(dop) == 2);
    end else if (idx == 2) begin
      case (iop)
        LW_OP, SW_OP, ADDI_OP: begin o.alusrca = 1; o.alusrcb = 2'b10; end
        ANDI_OP: begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = 2'b11; end
        R_OP:    begin o.alusrca = 1; o.aluop = 2'b10; end
        J_OP:    begin o.pcsrc = 2'b10; o.pcen = 1; end
        default: begin o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = tk; end
      endcase
    end else if (idx == 3) begin
      case (iop)
        LW_OP:   o.iord = 1;
        SW_OP:   begin o.iord = 1; o.memwrite = 1; end
        R_OP:    begin o.regdst = 1; o.regwrite = 1; end
        default: o.regwrite = 1;
      endcase
    end else begin
      o.memtoreg = 1; o.regwrite = 1;
    end
    return o;
  endfunction

  initial begin : compare_proc
    outs_t want;
    bit    waits;
    forever begin
      @(negedge clk);
      if (!reset_n || m_rst) want = '0;
      else want = mexp(m_idx, bus.op, m_op, bus.zero, bus.neg, bus.mem_ready);
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL cycle_outs t=%0t step=%0d got=%h want=%h", $time, m_idx, act, want);
      end
      @(posedge clk);
      if (!reset_n) m_rst = 1'b1;
      else if (m_rst) begin
        m_rst = 1'b0;
        m_idx = 0;
      end else begin
        if (m_idx == 1) m_op = bus.op;
        waits = (m_idx == 0) || (m_idx == 3 && (m_op == LW_OP || m_op == SW_OP));
        if (!(waits && !bus.mem_ready)) m_idx++;
        if (m_idx >= ilen(m_op)) m_idx = 0;
      end
    end
  end

  outs_t rec [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic [5:0] o, input int n, input logic [15:0] rdy,
                     input logic z, input logic ng);
    for (int i = 0; i < n; i++) begin
      bus.op = o; bus.zero = z; bus.neg = ng; bus.mem_ready = rdy[i];
      @(negedge clk);
      rec[i] = act;
      tick();
    end
    chk("fetch_entry", {rec[0].irwrite, rec[0].pcen}, 2'b11);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [10];
    int r;
    tbl = '{R_OP, LW_OP, SW_OP, BEQ_OP, BNE_OP, BLT_OP, BGE_OP, ADDI_OP, ANDI_OP, J_OP};
    r = $urandom_range(0, 11);
    if (r < 10) return tbl[r];
    return 6'($urandom);
  endfunction

  initial begin : drive_proc
    logic [5:0] bops [4];
    logic       bz [4];
    logic       bn [4];
    logic       bp [4];
    int         cnt;
    bus.op = R_OP; bus.zero = 0; bus.neg = 0; bus.mem_ready = 1;
    reset_n = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", act, 0);
    end
    @(posedge clk); #1;
    reset_n = 1;
    tick();

    // R-type
    seq(R_OP, 4, 16'hFFFF, 0, 0);
    chk("r_decode_srcb", rec[1].alusrcb, 2'b11);
    chk("r_ex_aluop", rec[2].aluop, 2'b10);
    chk("r_wb_regwrite_regdst", {rec[3].regwrite, rec[3].regdst}, 2'b11);

    // LW with two wait cycles in MEMRD
    seq(LW_OP, 7, 16'hFFE7, 0, 0);
    chk("lw_memrd_iord", {rec[3].iord, rec[4].iord, rec[5].iord}, 3'b111);
    cnt = 0;
    for (int i = 0; i < 7; i++) cnt += int'(rec[i].memtoreg & rec[i].regwrite);
    chk("lw_wb_once", cnt, 1);
    chk("lw_wb_cycle", {rec[6].memtoreg, rec[6].regwrite}, 2'b11);

    // ANDI then J
    seq(ANDI_OP, 4, 16'hFFFF, 0, 0);
    chk("andi_ex", {rec[2].aluop, rec[2].alusrcb}, 4'b1110);
    chk("andi_wb", {rec[3].regwrite, rec[3].regdst}, 2'b10);
    seq(J_OP, 3, 16'hFFFF, 0, 0);
    chk("j_ex", {rec[2].pcsrc, rec[2].pcen}, 3'b101);

    // Branches
    bops = '{BEQ_OP, BNE_OP, BLT_OP, BGE_OP};
    bz   = '{1'b1, 1'b1, 1'b0, 1'b0};
    bn   = '{1'b0, 1'b0, 1'b1, 1'b1};
    bp   = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int b = 0; b < 4; b++) begin
      seq(bops[b], 3, 16'hFFFF, bz[b], bn[b]);
      chk("branch_pcen", rec[2].pcen, bp[b]);
      chk("branch_pcsrc_aluop", {rec[2].pcsrc, rec[2].aluop}, 4'b0101);
    end

    // Illegal opcode
    seq(6'b111111, 2, 16'hFFFF, 0, 0);
    chk("illegal_flag", {rec[0].illegal, rec[1].illegal}, 2'b01);
    chk("illegal_no_write", {rec[0].regwrite, rec[0].memwrite, rec[1].regwrite, rec[1].memwrite}, 0);

    // SW stalled, then reset mid-stall
    seq(SW_OP, 5, 16'hFFE7, 0, 0);
    chk("sw_memwrite_held", {rec[3].memwrite, rec[4].memwrite}, 2'b11);
    bus.mem_ready = 0;
    #2;
    chk("sw_memwrite_before_rst", act.memwrite, 1);
    reset_n = 0;
    #1;
    chk("sw_rst_async", act, 0);
    @(negedge clk);
    chk("sw_rst_hold", act, 0);
    @(posedge clk); #1;
    reset_n = 1;
    bus.mem_ready = 1;
    tick();
    seq(R_OP, 4, 16'hFFFF, 0, 0);

    // Randomized traffic, with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.zero = 1'($urandom_range(0, 1));
      bus.neg  = 1'($urandom_range(0, 1));
      if (!m_rst && m_idx == 0) bus.op = pick_op();
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset_n = 0;
        #1;
        chk("rand_rst_async", act, 0);
        @(posedge clk); #1;
        reset_n = 1;
      end
      tick();
    end

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the MIPS core; replaces single-cycle main-decoder sequencing.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-memory, ALU, register-file and PC enables of the multicycle datapath.
- Supports RTYPE, LW, SW, BEQ, BNE, BLT, BGE, ADDI, ANDI and J.
- Waits on a memory-ready handshake.

Parameters:
MEM_WAIT_EN, 1, when 1 the memory states hold until mem_ready=1; when 0 mem_ready is ignored and treated as 1.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  opcode, instr[31:26] from the instruction register
zero  in  1  ALU result == 0
neg  in  1  ALU result[31] (sign of rs-rt)
mem_ready  in  1  shared memory completes the current access this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
regdst  out  1  write-register select: 1=rd, 0=rt
memtoreg  out  1  writeback select: 1=Data, 0=ALUOut
regwrite  out  1  register file write
alusrca  out  1  ALU A select: 0=PC, 1=A
alusrcb  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
aluop  out  2  to the ALU decoder: 00 add, 01 sub, 10 funct, 11 and
pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
pcen  out  1  PC register enable
illegal  out  1  one-cycle flag for an unsupported opcode

Behaviour:
- Moore FSM. All outputs are a combinational decode of the state register, plus pcen, illegal and the mem_ready qualifiers listed below.
- Outputs not listed for a state are 0.
- States:
  - S_RST: held while reset_n=0. All outputs 0. Goes to FETCH on the first clk after reset_n deasserts.
  - FETCH: iord=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite are asserted only when mem_ready=1. Goes to DECODE when ready; otherwise stays in FETCH.
  - DECODE: alusrcb=11, aluop=00. Next state by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100, 000101, 000001, 100110 -> BRANCHEX
    - 001000 -> ADDIEX
    - 001100 -> ANDIEX
    - 000010 -> JEX
    - any other op -> FETCH, with illegal=1 for this cycle.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD: iord=1. Goes to MEMWB when mem_ready=1; otherwise stays.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH.
  - MEMWR: iord=1, memwrite=1, held until mem_ready=1, then -> FETCH. Exactly one write is committed.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10. -> ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH.
  - BRANCHEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. -> IMMWB.
  - ANDIEX: alusrca=1, alusrcb=10, aluop=11. -> IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1. -> FETCH.
  - JEX: pcsrc=10, pcwrite=1. -> FETCH.
- Branch condition (taken):
  - BEQ: zero
  - BNE: !zero
  - BLT: neg
  - BGE: !neg
  - BLT and BGE are a signed compare via the subtract sign.
- pcen = pcwrite | (branch & taken).
- op is sampled only in DECODE and BRANCHEX; the instruction register holds it stable.
- Latency with zero wait states:
  - LW: 5 cycles
  - RTYPE, SW, ADDI, ANDI: 4 cycles
  - BEQ, BNE, BLT, BGE, J: 3 cycles
- Each wait cycle on mem_ready adds 1 cycle.
- reset_n falling in any state forces S_RST immediately, with all outputs 0 asynchronously. An in-flight write is abandoned: memwrite drops at once.
- An unknown or X op in DECODE never stalls; the FSM always returns to FETCH.

Decomposition:
- Package mc_pkg holds:
  - the state enum statetype_t (logic [3:0])
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_ADDI, OP_ANDI, OP_J
  - the aluop and alusrcb encodings
- One sub-module, mc_branch_cond: combinational; op, zero, neg -> taken.
- The next-state and output decode stay in mc_controller.

Test Plan:
- Reset and R-type:
  - Stimulus: hold reset_n=0 for 3 cycles, release, mem_ready=1, op=000000.
  - Required: all outputs 0 during reset; then FETCH (irwrite=1, pcen=1), DECODE, RTYPEEX (aluop=10), ALUWB (regwrite=1, regdst=1); back in FETCH on cycle 5.
- LW with wait states:
  - Stimulus: op=100011, mem_ready low for 2 cycles in MEMRD.
  - Required: MEMRD lasts 3 cycles with iord=1; MEMWB asserts memtoreg=1 and regwrite=1 exactly once; 7 cycles total.
- SW stall with reset:
  - Stimulus: op=101011, mem_ready=0 in MEMWR; assert reset_n=0 mid-stall.
  - Required: memwrite=1 held until reset, then 0 within the same cycle; state is S_RST.
- Branches:
  - Stimulus: one run per op; BEQ zero=1, BNE zero=1, BLT neg=1, BGE neg=1.
  - Required: BRANCHEX pcen = 1, 0, 1, 0 respectively; pcsrc=01 and aluop=01 in each.
- ANDI and J:
  - Stimulus: op=001100, then op=000010.
  - Required: ANDIEX has aluop=11 and alusrcb=10, then IMMWB has regwrite=1 and regdst=0; JEX has pcsrc=10 and pcen=1, 3 cycles total.
- Illegal op:
  - Stimulus: op=111111.
  - Required: illegal=1 for exactly 1 cycle in DECODE, no regwrite or memwrite asserted, next state FETCH.
